demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux_router.sv
// 1-to-4 demux router: captures one word, presents it to the selected destination, drops it on timeout.
// Optional DEMUX_ROUTER_STATS_EN adds pkt_cnt, per-destination delivered-word counters.
module demux_router #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              rr_mode,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              drop_pulse
`ifdef DEMUX_ROUTER_STATS_EN
    ,
    output logic [63:0]       pkt_cnt
`endif
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] W_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2} state_t;

    state_t              r_state;
    logic [1:0]          r_rr_ptr;
    logic                r_rr_cap;
    logic [CW-1:0]       r_wait;
    logic [3:0]          r_out_valid;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_sel;
    logic                r_drop;

    logic                w_ready_sel;
    logic [1:0]          w_dest;
    logic                w_timeout;

    // Only the selected destination's ready matters; others are don't-care.
    assign w_ready_sel = out_ready[r_sel];
    assign w_dest      = rr_mode ? r_rr_ptr : in_dest;
    assign w_timeout   = (TIMEOUT != 0) && (r_wait == W_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 2'd0;
            r_rr_cap    <= 1'b0;
            r_wait      <= '0;
            r_out_valid <= 4'd0;
            r_data      <= '0;
            r_sel       <= 2'd0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_data      <= in_data;
                    r_sel       <= w_dest;
                    r_rr_cap    <= rr_mode;
                    r_wait      <= '0;
                    r_out_valid <= 4'b0001 << w_dest;
                    r_state     <= SEND;
                end
                SEND: begin
                    // Ready on the last wait cycle takes priority over the timeout.
                    if (w_ready_sel) begin
                        r_out_valid <= 4'd0;
                        r_state     <= IDLE;
                        if (r_rr_cap)
                            r_rr_ptr <= r_rr_ptr + 2'd1;
                    end else if (w_timeout) begin
                        r_out_valid <= 4'd0;
                        r_drop      <= 1'b1;
                        r_state     <= DROP;
                    end else if (TIMEOUT != 0) begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                DROP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_ROUTER_STATS_EN
    logic [3:0][15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == SEND && w_ready_sel)
            r_cnt[r_sel] <= r_cnt[r_sel] + 16'd1;
    end

    assign pkt_cnt = r_cnt;
`endif

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_data   = r_data;
    assign sel        = r_sel;
    assign drop_pulse = r_drop;
endmodule
